morty_lsu: RTL and testbench
============================

MORTY_LSU -- requirements
Module: morty_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles without ack/err before the access is aborted as a bus error.
REQ-002 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, asynchronous active-low reset), listed first.
REQ-003 SHALL have mem_valid_i (in, 1): a load/store sits in the MEM stage.
REQ-004 SHALL have mem_we_i (in, 1): 1 = store, 0 = load.
REQ-005 SHALL have mem_size_i (in, 2): 00 byte, 01 half, 10 word; 11 is illegal and is handled as word.
REQ-006 SHALL have mem_unsigned_i (in, 1): zero-extend loads instead of sign-extending.
REQ-007 SHALL have mem_addr_i (in, 32) and mem_wdata_i (in, 32).
REQ-008 SHALL have kill_i (in, 1): exception flush; the pending access is abandoned.
REQ-009 SHALL have mem_rdata_o (out, 32): extended load data.
REQ-010 SHALL have mem_stall_req_o (out, 1): drives the control unit's memory stall request.
REQ-011 SHALL have misaligned_o (out, 1) and bus_err_o (out, 1): exception causes, each a one-cycle pulse.
REQ-012 SHALL have the Wishbone master ports dwbm_cyc_o, dwbm_stb_o, dwbm_we_o (out, 1), dwbm_addr_o (out, 32), dwbm_dat_o (out, 32), dwbm_sel_o (out, 4), dwbm_dat_i (in, 32), dwbm_ack_i (in, 1) and dwbm_err_i (in, 1).

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 Misalignment SHALL mean half with addr[0]=1, or word with addr[1:0]!=0.
REQ-015 In IDLE with mem_valid_i, aligned and !kill_i: mem_stall_req_o=1 combinationally, the request is registered and the FSM goes to BUSY.
REQ-016 In IDLE with mem_valid_i and misaligned: no bus cycle, no stall, misaligned_o=1 for that cycle, the FSM stays in IDLE.
REQ-017 In BUSY: cyc/stb=1, addr = {mem_addr[31:2],2'b00}, and mem_stall_req_o=1.
REQ-018 Byte lanes SHALL be: sel = 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
REQ-019 Store data SHALL be replicated: byte {4{b}}, half {2{h}}, word unchanged.
REQ-020 BUSY with dwbm_ack_i: cyc/stb drop that cycle; load data is extracted per addr[1:0], extended per size/unsigned, and registered; the FSM goes to DONE.
REQ-021 BUSY with dwbm_err_i, or the timeout counter reaching TIMEOUT-1: bus_err_o=1 for one cycle in DONE; mem_rdata_o=0; the FSM goes to DONE.
REQ-022 In DONE: mem_stall_req_o=0 for exactly one cycle, mem_rdata_o holds the result, and the next state is IDLE unconditionally, so the same instruction is never reissued.
REQ-023 A load SHALL occupy 3 cycles from first request to the pipeline advancing when ack arrives one cycle after stb (IDLE, BUSY, DONE).
REQ-024 kill_i in BUSY: cyc/stb drop the next cycle, no exception is raised, and the FSM goes to IDLE.
REQ-025 Any ack arriving after a kill_i abort SHALL be ignored.
REQ-026 Simultaneous ack and kill_i: kill_i wins.
REQ-027 Simultaneous ack and err: err wins.
REQ-028 The timeout counter SHALL be 8 bits, cleared on entry to BUSY, and saturating.
REQ-029 mem_rdata_o SHALL hold its last value outside DONE.

Reset
REQ-030 rst_i low SHALL asynchronously force: FSM to IDLE, counter to 0, and all registered outputs to 0 (cyc, stb, we, addr, dat, sel, rdata, bus_err_o).
REQ-031 Reset during BUSY SHALL drop cyc/stb immediately, with no completion or exception pulse afterwards.
REQ-032 Release of rst_i SHALL be sampled synchronously; the first access may start on the first clock edge after deassertion.

Structure
REQ-033 FSM state encodings, size codes (BYTE/HALF/WORD) and the default TIMEOUT SHALL live in the shared morty_pkg package.
REQ-034 One sub-module, morty_lsu_align, SHALL be combinational and produce sel, store replication and load extract/extend; the FSM remains in morty_lsu.

Verification
REQ-035 Scenario: LB at addr 0x1003, bus returns 0x80FFFFFF, ack after 1 cycle -> sel=1000, mem_rdata_o=0xFFFFFF80, stall for 2 cycles then released.
REQ-036 Scenario: SH at 0x2002, wdata 0x0000BEEF -> dat_o=0xBEEFBEEF, sel=1100, we=1.
REQ-037 Scenario: LW at 0x3001 -> misaligned_o pulses once, cyc stays 0, stall stays 0.
REQ-038 Scenario: LW with no ack and TIMEOUT=4 -> cyc held 4 cycles, bus_err_o pulses once, rdata=0.
REQ-039 Scenario: kill_i in the second BUSY cycle with ack in the same cycle -> no DONE, no error, FSM back in IDLE.
REQ-040 Scenario: rst_i low mid-BUSY -> cyc=0 with no clock edge; after release, a new LBU at 0x0 returns 0x000000xx zero-extended.

Source files
------------

// File: rtl/morty_pkg.sv
// Shared definitions for the MORTY load/store unit: FSM encodings, access
// size codes, default bus timeout and the alignment rule.
package morty_pkg;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_BUSY = 2'd1;
  localparam lsu_state_t ST_DONE = 2'd2;

  typedef logic [1:0] mem_size_t;
  localparam mem_size_t SZ_BYTE = 2'b00;
  localparam mem_size_t SZ_HALF = 2'b01;
  localparam mem_size_t SZ_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Size code 11 is treated as a word everywhere.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/morty_lsu_align.sv
// Combinational byte-lane logic: store lane select and replication, and
// load byte/half extraction with sign or zero extension.
module morty_lsu_align
  import morty_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_dat,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_bus,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_sh;
  logic        w_sign;

  always_comb begin
    case (i_st_size)
      SZ_BYTE: begin
        o_st_sel = 4'b0001 << i_st_addr_lo;
        o_st_dat = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_sel = 4'b0011 << i_st_addr_lo;
        o_st_dat = {2{i_st_wdata[15:0]}};
      end
      default: begin
        o_st_sel = 4'b1111;
        o_st_dat = i_st_wdata;
      end
    endcase
  end

  // Word accesses are aligned, so the shift is zero and w_sh is the raw bus word.
  assign w_sh = i_ld_bus >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    case (i_ld_size)
      SZ_BYTE: begin
        w_sign    = ~i_ld_unsigned & w_sh[7];
        o_ld_data = {{24{w_sign}}, w_sh[7:0]};
      end
      SZ_HALF: begin
        w_sign    = ~i_ld_unsigned & w_sh[15];
        o_ld_data = {{16{w_sign}}, w_sh[15:0]};
      end
      default: o_ld_data = w_sh;
    endcase
  end

endmodule

// File: rtl/morty_lsu.sv
// MEM-stage load/store unit: one Wishbone access per instruction through an
// IDLE -> BUSY -> DONE sequence, with misalignment, bus-error and timeout handling.
module morty_lsu
  import morty_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        kill_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stall_req_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic        r_unsigned;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic        w_misaligned;
  logic        w_idle;
  logic        w_busy;
  logic        w_start;
  logic        w_timeout;
  logic        w_fail;
  logic        w_ack;
  logic [3:0]  w_st_sel;
  logic [31:0] w_st_dat;
  logic [31:0] w_ld_data;

  morty_lsu_align u_align (
    .i_st_size     (mem_size_i),
    .i_st_addr_lo  (mem_addr_i[1:0]),
    .i_st_wdata    (mem_wdata_i),
    .o_st_sel      (w_st_sel),
    .o_st_dat      (w_st_dat),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_unsigned (r_unsigned),
    .i_ld_bus      (dwbm_dat_i),
    .o_ld_data     (w_ld_data)
  );

  assign w_misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_busy       = (r_state == ST_BUSY);
  assign w_start      = w_idle & mem_valid_i & ~w_misaligned & ~kill_i;
  assign w_timeout    = (r_cnt == TIMEOUT_LAST);
  // Priority in BUSY: kill, then err/timeout, then ack.
  assign w_fail       = w_busy & ~kill_i & (dwbm_err_i | w_timeout);
  assign w_ack        = w_busy & ~kill_i & ~dwbm_err_i & ~w_timeout & dwbm_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_addr_lo  <= '0;
      r_unsigned <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_rdata    <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= w_fail;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_BUSY;
            r_cnt      <= '0;
            r_cyc      <= 1'b1;
            r_stb      <= 1'b1;
            r_we       <= mem_we_i;
            r_addr     <= {mem_addr_i[31:2], 2'b00};
            r_dat      <= w_st_dat;
            r_sel      <= w_st_sel;
            r_size     <= mem_size_i;
            r_addr_lo  <= mem_addr_i[1:0];
            r_unsigned <= mem_unsigned_i;
          end
        end
        ST_BUSY: begin
          if (kill_i) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
          end else if (w_fail || w_ack) begin
            r_state <= ST_DONE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            if (w_fail) begin
              r_rdata <= '0;
            end else if (!r_we) begin
              r_rdata <= w_ld_data;
            end
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_stall_req_o = w_start | w_busy;
  assign misaligned_o    = w_idle & mem_valid_i & w_misaligned & ~kill_i;
  assign bus_err_o       = r_bus_err;
  assign mem_rdata_o     = r_rdata;
  assign dwbm_cyc_o      = r_cyc;
  assign dwbm_stb_o      = r_stb;
  assign dwbm_we_o       = r_we;
  assign dwbm_addr_o     = r_addr;
  assign dwbm_dat_o      = r_dat;
  assign dwbm_sel_o      = r_sel;

endmodule

// File: tb/tb_morty_lsu.sv
// Directed bench for morty_lsu: a transaction-level model sets per-cycle
// expectations, a negedge process compares every output against them.
module tb_morty_lsu;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, mem_we_i, mem_unsigned_i, kill_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_stall_req_o, misaligned_o, bus_err_o;
  logic        dwbm_cyc_o, dwbm_stb_o, dwbm_we_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_ack_i, dwbm_err_i;

  morty_lsu #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .kill_i(kill_i), .mem_rdata_o(mem_rdata_o), .mem_stall_req_o(mem_stall_req_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
    .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_we_o(dwbm_we_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  logic        exp_cyc, exp_we, exp_stall, exp_mis, exp_berr;
  logic [31:0] exp_addr, exp_dat, exp_rdata;
  logic [3:0]  exp_sel;

  int          stall_cnt, cyc_cnt, mis_cnt, berr_cnt;
  logic [31:0] last_dat;
  logic [3:0]  last_sel;
  logic        last_we;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] s, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] r = '0;
    int lo = int'(a[1:0]);
    for (int i = 0; i < nbytes(s); i++)
      if (lo + i < 4) r[lo + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_dat(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic uns,
                                             input logic [31:0] a, input logic [31:0] bus);
    int n = nbytes(s);
    logic [63:0] v;
    v = {32'b0, bus >> (8 * int'(a[1:0]))} & ((64'd1 << (8 * n)) - 64'd1);
    if (!uns && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("cyc", 32'(dwbm_cyc_o), 32'(exp_cyc));
      check("stb", 32'(dwbm_stb_o), 32'(exp_cyc));
      if (exp_cyc) begin
        check("we", 32'(dwbm_we_o), 32'(exp_we));
        check("addr", dwbm_addr_o, exp_addr);
        check("dat", dwbm_dat_o, exp_dat);
        check("sel", 32'(dwbm_sel_o), 32'(exp_sel));
      end
      check("stall", 32'(mem_stall_req_o), 32'(exp_stall));
      check("misaligned", 32'(misaligned_o), 32'(exp_mis));
      check("bus_err", 32'(bus_err_o), 32'(exp_berr));
      check("rdata", mem_rdata_o, exp_rdata);
      if (mem_stall_req_o) stall_cnt++;
      if (misaligned_o) mis_cnt++;
      if (bus_err_o) berr_cnt++;
      if (dwbm_cyc_o) begin
        cyc_cnt++;
        last_dat = dwbm_dat_o;
        last_sel = dwbm_sel_o;
        last_we  = dwbm_we_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_bus();
    mem_valid_i = 0; kill_i = 0; dwbm_ack_i = 0; dwbm_err_i = 0;
    exp_cyc = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      idle_bus();
    end
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; cyc_cnt = 0; mis_cnt = 0; berr_cnt = 0;
  endtask

  // ack_at/err_at/kill_at: BUSY cycle (1-based) in which that input is raised; 0 = never.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] bus,
                        input int ack_at, input int err_at, input int kill_at);
    logic mis;
    bit killed, failed, fin;
    int j;
    mis = model_mis(size, addr);
    tick();
    idle_bus();
    mem_valid_i = 1; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    mem_addr_i = addr; mem_wdata_i = wdata; dwbm_dat_i = bus;
    exp_stall = !mis; exp_mis = mis;
    if (mis) begin
      tick();
      idle_bus();
      return;
    end
    j = 0; killed = 0; failed = 0; fin = 0;
    while (!fin) begin
      tick();
      j++;
      exp_cyc = 1; exp_we = we; exp_addr = {addr[31:2], 2'b00};
      exp_dat = model_dat(size, wdata); exp_sel = model_sel(size, addr);
      exp_stall = 1; exp_mis = 0; exp_berr = 0;
      dwbm_ack_i = (j == ack_at); dwbm_err_i = (j == err_at); kill_i = (j == kill_at);
      if (j == kill_at) begin killed = 1; fin = 1; end
      else if (j == err_at || j == TO) begin failed = 1; fin = 1; end
      else if (j == ack_at) fin = 1;
    end
    tick();
    dwbm_ack_i = 0; dwbm_err_i = 0; kill_i = 0;
    exp_cyc = 0; exp_stall = 0;
    if (killed) begin
      mem_valid_i = 0;
      dwbm_ack_i = 1;
      tick();
      idle_bus();
      return;
    end
    exp_berr = failed;
    if (failed) exp_rdata = '0;
    else if (!we) exp_rdata = model_load(size, uns, addr, bus);
    tick();
    idle_bus();
  endtask

  initial begin
    rst_i = 0;
    mem_we_i = 0; mem_size_i = 0; mem_unsigned_i = 0;
    mem_addr_i = '0; mem_wdata_i = '0; dwbm_dat_i = '0;
    idle_bus();
    exp_rdata = '0; exp_we = 0; exp_addr = '0; exp_dat = '0; exp_sel = '0;
    clr_cnt();
    #3;
    check("rst_cyc", 32'(dwbm_cyc_o), 32'd0);
    check("rst_stb", 32'(dwbm_stb_o), 32'd0);
    check("rst_sel", 32'(dwbm_sel_o), 32'd0);
    check("rst_dat", dwbm_dat_o, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_berr", 32'(bus_err_o), 32'd0);
    #9 rst_i = 1;
    chk_en = 1;
    idle(2);

    check("pin_load_lb", model_load(2'b00, 1'b0, 32'h1003, 32'h80FFFFFF), 32'hFFFFFF80);
    check("pin_dat_sh", model_dat(2'b01, 32'h0000BEEF), 32'hBEEFBEEF);
    check("pin_sel_sh", 32'(model_sel(2'b01, 32'h2002)), 32'h0000000C);
    check("pin_load_lhu", model_load(2'b01, 1'b1, 32'h7002, 32'h9ABC1234), 32'h00009ABC);

    clr_cnt();
    access(0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FFFFFF, 1, 0, 0);
    check("lb_rdata", mem_rdata_o, 32'hFFFFFF80);
    check("lb_sel", 32'(last_sel), 32'h8);
    check("lb_stall_cycles", stall_cnt, 2);

    access(1, 2'b01, 0, 32'h2002, 32'h0000BEEF, 32'h0, 1, 0, 0);
    check("sh_dat", last_dat, 32'hBEEFBEEF);
    check("sh_sel", 32'(last_sel), 32'hC);
    check("sh_we", 32'(last_we), 32'd1);

    clr_cnt();
    access(0, 2'b10, 0, 32'h3001, 32'h0, 32'h0, 1, 0, 0);
    idle(2);
    check("lw_mis_pulses", mis_cnt, 1);
    check("lw_mis_cyc", cyc_cnt, 0);
    check("lw_mis_stall", stall_cnt, 0);

    access(0, 2'b00, 0, 32'h7001, 32'h0, 32'h11223344, 2, 0, 0);
    clr_cnt();
    access(0, 2'b10, 0, 32'h4000, 32'h0, 32'h12345678, 0, 0, 0);
    check("to_cyc_cycles", cyc_cnt, TO);
    check("to_berr_pulses", berr_cnt, 1);
    check("to_rdata", mem_rdata_o, 32'd0);

    clr_cnt();
    access(0, 2'b10, 0, 32'h5000, 32'h0, 32'hCAFEF00D, 2, 0, 2);
    idle(2);
    check("kill_berr", berr_cnt, 0);
    check("kill_rdata", mem_rdata_o, 32'd0);
    check("kill_cyc_cycles", cyc_cnt, 2);

    access(0, 2'b01, 0, 32'h6002, 32'h0, 32'h80010000, 1, 0, 0);
    check("lh_rdata", mem_rdata_o, 32'hFFFF8001);
    access(0, 2'b01, 1, 32'h6002, 32'h0, 32'hABCD1234, 1, 1, 0);
    check("ackerr_rdata", mem_rdata_o, 32'd0);
    access(0, 2'b01, 1, 32'h7002, 32'h0, 32'h9ABC1234, 3, 0, 0);
    access(1, 2'b00, 0, 32'h8001, 32'h000000A7, 32'h0, 2, 0, 0);
    check("sb_dat", last_dat, 32'hA7A7A7A7);
    access(1, 2'b10, 0, 32'h9000, 32'h13579BDF, 32'h0, 3, 0, 0);
    access(0, 2'b11, 0, 32'hB000, 32'h0, 32'hDEADBEEF, 1, 0, 0);
    check("size11_rdata", mem_rdata_o, 32'hDEADBEEF);
    access(0, 2'b01, 0, 32'hC001, 32'h0, 32'h0, 1, 0, 0);
    access(1, 2'b10, 0, 32'hD004, 32'h01020304, 32'h0, 0, 2, 0);
    idle(1);

    // Reset in the middle of a BUSY cycle, then a fresh LBU.
    tick();
    idle_bus();
    mem_valid_i = 1; mem_we_i = 0; mem_size_i = 2'b10; mem_unsigned_i = 0;
    mem_addr_i = 32'h40; exp_stall = 1;
    tick();
    exp_cyc = 1; exp_we = 0; exp_addr = 32'h40; exp_dat = mem_wdata_i;
    exp_sel = 4'hF; exp_stall = 1;
    #2;
    chk_en = 0;
    rst_i = 0;
    mem_valid_i = 0;
    #1;
    check("rst_busy_cyc", 32'(dwbm_cyc_o), 32'd0);
    check("rst_busy_stb", 32'(dwbm_stb_o), 32'd0);
    check("rst_busy_rdata", mem_rdata_o, 32'd0);
    idle_bus();
    exp_rdata = '0;
    @(negedge clk_i);
    #2 rst_i = 1;
    chk_en = 1;
    clr_cnt();
    idle(3);
    check("rst_no_berr", berr_cnt, 0);
    check("rst_no_cyc", cyc_cnt, 0);
    access(0, 2'b00, 1, 32'h0, 32'h0, 32'h123456A5, 1, 0, 0);
    check("lbu_rdata", mem_rdata_o, 32'h000000A5);
    idle(2);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
